// File: rtl/regfile_pkg.sv
// Shared types and constants for the regfile writeback arbiter.
package regfile_pkg;

    localparam int unsigned DATA_W   = 64;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned ZERO_REG = 31;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_starve_ctr.sv
// Saturating count of consecutive denied cycles for one requester;
// forceReq flags that the requester must win the next cycle.
module wb_starve_ctr #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic waitValid,
    input  logic waitGrant,
    output logic forceReq
);

    logic [3:0] waitCnt;
    logic [3:0] cntNext;

    always_comb begin
        cntNext = waitCnt;
        if (!waitValid || waitGrant) begin
            cntNext = '0;
        end else if (waitCnt < 4'(MAX_WAIT)) begin
            cntNext = waitCnt + 4'd1;
        end
    end

    // Looking at the next count lets FORCE start the cycle right after the MAX_WAIT-th denial.
    assign forceReq = (cntNext == 4'(MAX_WAIT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            waitCnt <= '0;
        end else begin
            waitCnt <= cntNext;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-port writeback arbiter for the regfile write port, port 0 priority with starvation guard.
// Optional grant statistics counters when WB_ARB_STATS_EN is defined.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W   = regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W   = regfile_pkg::ADDR_W,
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned ZERO_REG = regfile_pkg::ZERO_REG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_reg,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_reg,
    input  logic [DATA_W-1:0] req1_data,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0] WriteData,
    output logic              p1_forced
`ifdef WB_ARB_STATS_EN
    ,
    output logic [31:0]       grant0_cnt,
    output logic [31:0]       grant1_cnt,
    output logic [31:0]       force_cnt
`endif
);

    import regfile_pkg::*;

    arb_state_t        state;
    arb_state_t        nextState;
    logic              grant0;
    logic              grant1;
    logic              forceReq;
    logic [ADDR_W-1:0] selReg;
    logic [DATA_W-1:0] selData;

    wb_starve_ctr #(
        .MAX_WAIT(MAX_WAIT)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .waitValid(req1_valid),
        .waitGrant(grant1),
        .forceReq (forceReq)
    );

    always_comb begin
        grant0    = 1'b0;
        grant1    = 1'b0;
        nextState = forceReq ? FORCE : NORMAL;
        if (!reset) begin
            case (state)
                NORMAL: begin
                    if (req0_valid) begin
                        grant0 = 1'b1;
                    end else if (req1_valid) begin
                        grant1 = 1'b1;
                    end
                end
                FORCE: begin
                    grant1 = req1_valid;
                end
                default: ;
            endcase
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign p1_forced  = (state == FORCE) && grant1;
    assign selReg     = grant1 ? req1_reg  : req0_reg;
    assign selData    = grant1 ? req1_data : req0_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= NORMAL;
        end else begin
            state <= nextState;
        end
    end

    // Index/data track every grant, including ZERO_REG; only the enable is suppressed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else begin
            RegWrite <= (grant0 || grant1) && (selReg != ADDR_W'(ZERO_REG));
            if (grant0 || grant1) begin
                WriteRegister <= selReg;
                WriteData     <= selData;
            end
        end
    end

`ifdef WB_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant0_cnt <= '0;
            grant1_cnt <= '0;
            force_cnt  <= '0;
        end else begin
            if (grant0) grant0_cnt <= grant0_cnt + 32'd1;
            if (grant1) grant1_cnt <= grant1_cnt + 32'd1;
            if (p1_forced) force_cnt <= force_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter with a behavioural regfile on its write port.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_reg, req1_reg;
    logic [63:0] req0_data, req1_data;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic        p1_forced;
`ifdef WB_ARB_STATS_EN
    logic [31:0] grant0_cnt, grant1_cnt, force_cnt;
`endif

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .DATA_W  (64),
        .ADDR_W  (5),
        .MAX_WAIT(4),
        .ZERO_REG(31)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_reg     (req0_reg),
        .req0_data    (req0_data),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_reg     (req1_reg),
        .req1_data    (req1_data),
        .RegWrite     (RegWrite),
        .WriteRegister(WriteRegister),
        .WriteData    (WriteData),
        .p1_forced    (p1_forced)
`ifdef WB_ARB_STATS_EN
        ,
        .grant0_cnt   (grant0_cnt),
        .grant1_cnt   (grant1_cnt),
        .force_cnt    (force_cnt)
`endif
    );

    // Regfile being fed: commits on the edge after the arbiter output cycle.
    logic [63:0] rf [32];
    initial for (int i = 0; i < 32; i++) rf[i] = '0;
    always @(posedge clk) begin
        if (RegWrite && WriteRegister != 5'd31) rf[WriteRegister] <= WriteData;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        v0;
        logic [4:0]  r0;
        logic [63:0] d0;
        logic        v1;
        logic [4:0]  r1;
        logic [63:0] d1;
        logic        rdy0;
        logic        rdy1;
        logic        frc;
        logic        rw;
        logic [4:0]  wr;
        logic [63:0] wd;
    } vec_t;

    vec_t vec [23];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        logic [63:0] p1Data;
        logic        expP1;
        logic [63:0] expWd;

        // {v0,r0,d0, v1,r1,d1, rdy0,rdy1,frc, rw,wr,wd}
        vec[0]  = '{1'b1, 5'd1,  64'h01, 1'b0, 5'd0,  64'h00, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1,  64'h01};
        vec[1]  = '{1'b1, 5'd2,  64'h02, 1'b0, 5'd0,  64'h00, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2,  64'h02};
        vec[2]  = '{1'b0, 5'd0,  64'h00, 1'b0, 5'd0,  64'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2,  64'h02};
        vec[3]  = '{1'b1, 5'd31, 64'hA0, 1'b0, 5'd0,  64'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd31, 64'hA0};
        vec[4]  = '{1'b1, 5'd5,  64'h11, 1'b1, 5'd5,  64'h22, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5,  64'h11};
        vec[5]  = '{1'b0, 5'd0,  64'h00, 1'b1, 5'd5,  64'h22, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5,  64'h22};
        vec[6]  = '{1'b1, 5'd8,  64'h80, 1'b1, 5'd7,  64'h77, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8,  64'h80};
        vec[7]  = '{1'b1, 5'd9,  64'h81, 1'b1, 5'd7,  64'h77, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9,  64'h81};
        vec[8]  = '{1'b1, 5'd10, 64'h82, 1'b1, 5'd7,  64'h77, 1'b1, 1'b0, 1'b0, 1'b1, 5'd10, 64'h82};
        vec[9]  = '{1'b1, 5'd11, 64'h83, 1'b1, 5'd7,  64'h77, 1'b1, 1'b0, 1'b0, 1'b1, 5'd11, 64'h83};
        vec[10] = '{1'b1, 5'd12, 64'h84, 1'b1, 5'd7,  64'h77, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7,  64'h77};
        vec[11] = '{1'b1, 5'd12, 64'h84, 1'b1, 5'd7,  64'h78, 1'b1, 1'b0, 1'b0, 1'b1, 5'd12, 64'h84};
        vec[12] = '{1'b1, 5'd13, 64'h85, 1'b1, 5'd7,  64'h78, 1'b1, 1'b0, 1'b0, 1'b1, 5'd13, 64'h85};
        vec[13] = '{1'b1, 5'd14, 64'h86, 1'b1, 5'd7,  64'h78, 1'b1, 1'b0, 1'b0, 1'b1, 5'd14, 64'h86};
        vec[14] = '{1'b1, 5'd15, 64'h87, 1'b1, 5'd7,  64'h78, 1'b1, 1'b0, 1'b0, 1'b1, 5'd15, 64'h87};
        vec[15] = '{1'b1, 5'd16, 64'h90, 1'b1, 5'd7,  64'h78, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7,  64'h78};
        vec[16] = '{1'b1, 5'd16, 64'h90, 1'b0, 5'd0,  64'h00, 1'b1, 1'b0, 1'b0, 1'b1, 5'd16, 64'h90};
        vec[17] = '{1'b1, 5'd21, 64'hA1, 1'b1, 5'd20, 64'h99, 1'b1, 1'b0, 1'b0, 1'b1, 5'd21, 64'hA1};
        vec[18] = '{1'b1, 5'd22, 64'hA2, 1'b1, 5'd20, 64'h99, 1'b1, 1'b0, 1'b0, 1'b1, 5'd22, 64'hA2};
        vec[19] = '{1'b1, 5'd23, 64'hA3, 1'b1, 5'd20, 64'h99, 1'b1, 1'b0, 1'b0, 1'b1, 5'd23, 64'hA3};
        vec[20] = '{1'b1, 5'd24, 64'hA4, 1'b1, 5'd20, 64'h99, 1'b1, 1'b0, 1'b0, 1'b1, 5'd24, 64'hA4};
        // FORCE pending but port 1 withdrew: nothing granted, outputs hold
        vec[21] = '{1'b1, 5'd25, 64'h55, 1'b0, 5'd0,  64'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd24, 64'hA4};
        vec[22] = '{1'b1, 5'd25, 64'h55, 1'b0, 5'd0,  64'h00, 1'b1, 1'b0, 1'b0, 1'b1, 5'd25, 64'h55};

        reset      = 1'b1;
        req0_valid = 1'b0; req0_reg = '0; req0_data = '0;
        req1_valid = 1'b1; req1_reg = 5'd3; req1_data = 64'h3;
        #2;
        check("reset RegWrite", RegWrite, 1'b0);
        check("reset WriteRegister", WriteRegister, 5'd0);
        check("reset WriteData", WriteData, 64'h0);
        check("reset req1_ready", req1_ready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        req1_valid = 1'b0;

        for (int k = 0; k < 23; k++) begin
            @(negedge clk);
            req0_valid = vec[k].v0; req0_reg = vec[k].r0; req0_data = vec[k].d0;
            req1_valid = vec[k].v1; req1_reg = vec[k].r1; req1_data = vec[k].d1;
            #1;
            check($sformatf("v%0d req0_ready", k), req0_ready, vec[k].rdy0);
            check($sformatf("v%0d req1_ready", k), req1_ready, vec[k].rdy1);
            check($sformatf("v%0d p1_forced", k), p1_forced, vec[k].frc);
            @(posedge clk);
            #1;
            check($sformatf("v%0d RegWrite", k), RegWrite, vec[k].rw);
            check($sformatf("v%0d WriteRegister", k), WriteRegister, vec[k].wr);
            check($sformatf("v%0d WriteData", k), WriteData, vec[k].wd);
        end

        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rf X1", rf[1], 64'h01);
        check("rf X2", rf[2], 64'h02);
        check("rf X5 later grant wins", rf[5], 64'h22);
        check("rf X7", rf[7], 64'h78);
        check("rf X20 withdrawn", rf[20], 64'h0);
        check("rf X31 zero", rf[31], 64'h0);
        check("idle RegWrite", RegWrite, 1'b0);

        // Async reset between a grant and its output commit, with port 1 already waiting
        @(negedge clk);
        req0_valid = 1'b1; req0_reg = 5'd3; req0_data = 64'h33;
        req1_valid = 1'b1; req1_reg = 5'd4; req1_data = 64'h44;
        @(negedge clk);
        req0_reg = 5'd6; req0_data = 64'h66;
        @(posedge clk);
        #1;
        check("pre-reset RegWrite", RegWrite, 1'b1);
        check("pre-reset WriteRegister", WriteRegister, 5'd6);
        #1;
        reset = 1'b1;
        #1;
        check("async reset RegWrite", RegWrite, 1'b0);
        check("in-reset req0_ready", req0_ready, 1'b0);
        check("in-reset req1_ready", req1_ready, 1'b0);
        @(posedge clk);
        #1;
        check("rf X3 committed", rf[3], 64'h33);
        check("rf X6 dropped", rf[6], 64'h0);

        // 4:1 pattern straight out of reset; port 1 forced on the 5th cycle proves the counter restarted
        @(negedge clk);
        reset  = 1'b0;
        p1Data = 64'h44;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            req0_valid = 1'b1; req0_reg = 5'(i + 1); req0_data = 64'(i + 256);
            req1_valid = 1'b1; req1_reg = 5'd4; req1_data = p1Data;
            expP1 = (i % 5 == 4);
            expWd = expP1 ? p1Data : 64'(i + 256);
            #1;
            check($sformatf("s%0d req0_ready", i), req0_ready, !expP1);
            check($sformatf("s%0d req1_ready", i), req1_ready, expP1);
            check($sformatf("s%0d p1_forced", i), p1_forced, expP1);
            @(posedge clk);
            #1;
            check($sformatf("s%0d WriteData", i), WriteData, expWd);
            if (expP1) p1Data = p1Data + 64'h1;
        end

`ifdef WB_ARB_STATS_EN
        check("grant0_cnt", grant0_cnt, 32'd16);
        check("grant1_cnt", grant1_cnt, 32'd4);
        check("force_cnt", force_cnt, 32'd4);
`endif

        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
